// File: rtl/pre_if_stage_pkg.sv
// Shared fetch-side definitions for the pre-IF stage: bus widths, reset PC
// and the SRAM-like bus size encoding.
package pre_if_stage_pkg;

    localparam int BR_BUS_WD       = 33;
    localparam int PS_TO_FS_BUS_WD = 33;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c000000;
    localparam logic [1:0]  SIZE_WORD        = 2'b10;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pre_if_stage_fetch_track_cnt.sv
// Outstanding-request and cancel counters for the instruction bus; flags
// responses that belong to fetches made stale by a redirect.
module pre_if_stage_fetch_track_cnt #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic fire,
    input  logic data_ok,
    input  logic load_cancel,
    input  logic stale_fire,
    output logic full,
    output logic resp_drop
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] outstanding_reg, outstanding_next;
    logic [CNT_W-1:0] cancel_reg, cancel_next;
    logic [CNT_W-1:0] out_adj;
    logic             retire;

    always_comb begin
        // A response with nothing outstanding (e.g. left over from before reset) is ignored.
        retire           = data_ok && (outstanding_reg != '0);
        resp_drop        = !reset && data_ok && (cancel_reg != '0);
        out_adj          = outstanding_reg - CNT_W'(retire);
        outstanding_next = out_adj + CNT_W'(fire);
        if (load_cancel) begin
            cancel_next = out_adj + CNT_W'(stale_fire);
        end else begin
            cancel_next = cancel_reg - CNT_W'(resp_drop) + CNT_W'(stale_fire);
        end
        full = outstanding_reg >= MAX_CNT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_reg <= '0;
            cancel_reg      <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            cancel_reg      <= cancel_next;
        end
    end

endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage: picks the next fetch PC, drives the instruction request
// channel and hands accepted PCs to IF, hiding fetches made stale by redirects.
module pre_if_stage
    import pre_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          CNT_W           = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    input  logic                       ws_flush,
    input  logic [31:0]                flush_pc,
    input  logic                       fs_allowin,
    output logic                       ps_to_fs_valid,
    output logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus,
    output logic                       inst_req,
    output logic                       inst_wr,
    output logic [1:0]                 inst_size,
    output logic [3:0]                 inst_wstrb,
    output logic [31:0]                inst_addr,
    output logic [31:0]                inst_wdata,
    input  logic                       inst_addr_ok,
    input  logic                       inst_data_ok,
    output logic                       resp_drop
);

    br_bus_t     br;
    logic [31:0] pc_reg, pc_next;
    logic        pending_reg, pending_next;
    logic [31:0] pend_addr_reg, pend_addr_next;
    logic        stale_reg, stale_next;
    logic        latch_valid_reg, latch_valid_next;
    logic        latch_flush_reg, latch_flush_next;
    logic [31:0] latch_pc_reg, latch_pc_next;
    logic        stall_reg, stall_next;
    logic [31:0] sel_addr;
    logic        fire, adef_pc, load_cancel, stale_fire, is_stale, full;

    assign br           = br_bus;
    assign inst_wr      = 1'b0;
    assign inst_size    = SIZE_WORD;
    assign inst_wstrb   = 4'b0000;
    assign inst_wdata   = 32'h0;
    assign ps_to_fs_bus = {adef_pc, inst_addr};

    always_comb begin
        fire             = 1'b0;
        inst_req         = 1'b0;
        inst_addr        = pc_reg;
        ps_to_fs_valid   = 1'b0;
        adef_pc          = 1'b0;
        sel_addr         = pc_reg;
        is_stale         = stale_reg;
        pc_next          = pc_reg;
        pending_next     = pending_reg;
        pend_addr_next   = pend_addr_reg;
        stale_next       = stale_reg;
        latch_valid_next = latch_valid_reg;
        latch_flush_next = latch_flush_reg;
        latch_pc_next    = latch_pc_reg;
        stall_next       = stall_reg;
        load_cancel      = 1'b0;
        stale_fire       = 1'b0;

        if (pending_reg) begin
            // The bus holds the pending address; redirects only go into the latch.
            inst_req  = 1'b1;
            inst_addr = pend_addr_reg;
            fire      = inst_addr_ok;
            if (ws_flush) begin
                latch_valid_next = 1'b1;
                latch_flush_next = 1'b1;
                latch_pc_next    = flush_pc;
                load_cancel      = 1'b1;
            end else if (br.taken && !(latch_valid_reg && latch_flush_reg)) begin
                latch_valid_next = 1'b1;
                latch_flush_next = 1'b0;
                latch_pc_next    = br.target;
                load_cancel      = 1'b1;
            end
            is_stale = stale_reg || load_cancel;
            if (fire) begin
                pending_next   = 1'b0;
                stale_next     = 1'b0;
                stale_fire     = is_stale;
                ps_to_fs_valid = !is_stale;
                pc_next        = pend_addr_reg + 32'd4;
            end else begin
                stale_next = is_stale;
            end
        end else if (ws_flush) begin
            pc_next          = flush_pc;
            latch_valid_next = 1'b0;
            stall_next       = 1'b0;
            load_cancel      = 1'b1;
        end else begin
            if (latch_valid_reg) begin
                sel_addr = latch_pc_reg;
            end else if (br.taken && !stall_reg) begin
                sel_addr    = br.target;
                load_cancel = 1'b1;
            end
            inst_addr        = sel_addr;
            pc_next          = sel_addr;
            latch_valid_next = 1'b0;
            if (!stall_reg && fs_allowin) begin
                if (is_misaligned(sel_addr)) begin
                    // Misaligned PC goes to IF as an exception carrier, never onto the bus.
                    ps_to_fs_valid = 1'b1;
                    adef_pc        = 1'b1;
                    stall_next     = 1'b1;
                end else if (!full) begin
                    inst_req = 1'b1;
                    fire     = inst_addr_ok;
                    if (fire) begin
                        ps_to_fs_valid = 1'b1;
                        pc_next        = sel_addr + 32'd4;
                    end else begin
                        pending_next   = 1'b1;
                        pend_addr_next = sel_addr;
                        stale_next     = 1'b0;
                    end
                end
            end
        end

        if (reset) begin
            inst_req       = 1'b0;
            fire           = 1'b0;
            ps_to_fs_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg          <= RESET_PC;
            pending_reg     <= 1'b0;
            pend_addr_reg   <= 32'h0;
            stale_reg       <= 1'b0;
            latch_valid_reg <= 1'b0;
            latch_flush_reg <= 1'b0;
            latch_pc_reg    <= 32'h0;
            stall_reg       <= 1'b0;
        end else begin
            pc_reg          <= pc_next;
            pending_reg     <= pending_next;
            pend_addr_reg   <= pend_addr_next;
            stale_reg       <= stale_next;
            latch_valid_reg <= latch_valid_next;
            latch_flush_reg <= latch_flush_next;
            latch_pc_reg    <= latch_pc_next;
            stall_reg       <= stall_next;
        end
    end

    pre_if_stage_fetch_track_cnt #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CNT_W          (CNT_W)
    ) u_track (
        .clk        (clk),
        .reset      (reset),
        .fire       (fire),
        .data_ok    (inst_data_ok),
        .load_cancel(load_cancel),
        .stale_fire (stale_fire),
        .full       (full),
        .resp_drop  (resp_drop)
    );

endmodule

// File: tb/tb_pre_if_stage.sv
// Randomised scoreboard bench for pre_if_stage: a program-flow model predicts
// delivered PCs, request gating and which responses must be dropped.
module tb_pre_if_stage;

    localparam logic [31:0] RST_PC = 32'h1c000000;
    localparam int          MAXO   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [32:0] br_bus = '0;
    logic        ws_flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        fs_allowin = 1'b0;
    logic        ps_to_fs_valid;
    logic [32:0] ps_to_fs_bus;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic        resp_drop;

    always #5 clk = ~clk;

    pre_if_stage dut (
        .clk           (clk),
        .reset         (reset),
        .br_bus        (br_bus),
        .ws_flush      (ws_flush),
        .flush_pc      (flush_pc),
        .fs_allowin    (fs_allowin),
        .ps_to_fs_valid(ps_to_fs_valid),
        .ps_to_fs_bus  (ps_to_fs_bus),
        .inst_req      (inst_req),
        .inst_wr       (inst_wr),
        .inst_size     (inst_size),
        .inst_wstrb    (inst_wstrb),
        .inst_addr     (inst_addr),
        .inst_wdata    (inst_wdata),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .resp_drop     (resp_drop)
    );

    int n_cmp = 0, n_fail = 0;
    int n_fire = 0, n_stale = 0, n_drop = 0, n_pseudo = 0;

    // Model state: architectural next PC, adef stall, observed pending request,
    // and one stale tag per accepted-but-unanswered request.
    logic [31:0] exp_pc = RST_PC;
    bit          stall_m = 0, unconsumed = 0;
    bit          pend_obs = 0, pend_stale = 0;
    logic [31:0] pend_addr_obs = '0;
    bit          inflight_q[$];

    function automatic bit mis(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mon_cycle();
        bit fl, br, fire, pre_full, exp_req, exp_pseudo, tag;
        fl       = ws_flush;
        br       = br_bus[32] && !fl;
        pre_full = inflight_q.size() >= MAXO;
        fire     = inst_req && inst_addr_ok;

        if (inst_data_ok) begin
            if (inflight_q.size() == 0) begin
                check("stray_drop", resp_drop, 0);
            end else begin
                tag = inflight_q.pop_front();
                check("resp_drop", resp_drop, tag);
                if (tag) n_drop++;
            end
        end else begin
            check("idle_drop", resp_drop, 0);
        end

        if (fl || br) begin
            exp_pc = fl ? flush_pc : br_bus[31:0];
            if (fl) stall_m = 0;
            foreach (inflight_q[i]) inflight_q[i] = 1'b1;
            if (pend_obs) pend_stale = 1;
        end

        if (pend_obs) begin
            check("req_hold", inst_req, 1);
            check("addr_hold", inst_addr, pend_addr_obs);
        end else begin
            exp_req    = !fl && !stall_m && fs_allowin && !pre_full && !mis(exp_pc);
            exp_pseudo = !fl && !stall_m && fs_allowin && mis(exp_pc);
            check("req", inst_req, exp_req);
            if (exp_req) check("req_addr", inst_addr, exp_pc);
            if (!fire) check("pseudo_valid", ps_to_fs_valid, exp_pseudo);
        end

        if (fire) begin
            if (pend_obs && pend_stale) begin
                check("stale_valid", ps_to_fs_valid, 0);
                inflight_q.push_back(1'b1);
                n_stale++;
            end else begin
                check("fire_valid", ps_to_fs_valid, 1);
                check("fire_bus", ps_to_fs_bus, {1'b0, exp_pc});
                exp_pc     = exp_pc + 32'd4;
                unconsumed = 0;
                inflight_q.push_back(1'b0);
                n_fire++;
            end
            pend_obs   = 0;
            pend_stale = 0;
        end else if (ps_to_fs_valid && !pend_obs) begin
            check("adef_bus", ps_to_fs_bus, {1'b1, exp_pc});
            stall_m    = 1;
            unconsumed = 0;
            n_pseudo++;
        end else if (pend_obs) begin
            check("pend_valid", ps_to_fs_valid, 0);
        end

        if (inst_req && !fire && !pend_obs) begin
            pend_obs      = 1;
            pend_addr_obs = inst_addr;
            pend_stale    = 0;
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                check("rst_req", inst_req, 0);
                check("rst_valid", ps_to_fs_valid, 0);
                check("rst_drop", resp_drop, 0);
                exp_pc     = RST_PC;
                stall_m    = 0;
                pend_obs   = 0;
                pend_stale = 0;
                unconsumed = 0;
                inflight_q.delete();
            end else begin
                mon_cycle();
            end
        end
    end

    task automatic step(input bit rst, input bit aok, input bit dok_en, input bit alw,
                        input bit fl, input logic [31:0] fpc, input bit br,
                        input logic [31:0] bt, input bit dok_force);
        @(negedge clk);
        reset        = rst;
        inst_addr_ok = aok;
        inst_data_ok = dok_force || (dok_en && inflight_q.size() != 0);
        fs_allowin   = alw;
        ws_flush     = fl;
        flush_pc     = fpc;
        br_bus       = {br, bt};
        if (!rst && (fl || br)) unconsumed = 1;
    endtask

    task automatic run(input int n, input bit aok, input bit dok);
        for (int i = 0; i < n; i++) step(0, aok, dok, 1, 0, '0, 0, '0, 0);
    endtask

    function automatic logic [31:0] rand_target(input bit misal);
        logic [31:0] t;
        t = 32'h1c000000 | (32'($urandom_range(0, 4095)) << 2);
        if (misal) t = t | 32'd2;
        return t;
    endfunction

    initial begin : stimulus
        int n0, d0, s0, p0;
        bit aok, dok, alw, fl, br;
        logic [31:0] bt, fpc;

        step(1, 0, 0, 0, 0, '0, 0, '0, 0);
        step(1, 0, 0, 0, 0, '0, 0, '0, 0);

        // Back-to-back sequential fetch, one-cycle response latency.
        n0 = n_fire;
        run(20, 1, 1);
        #6;
        check("seq_fires", n_fire - n0, 20);

        // Branch arriving while 1c000004 waits for addr_ok.
        step(1, 0, 0, 0, 0, '0, 0, '0, 0);
        d0 = n_drop; s0 = n_stale;
        step(0, 1, 1, 1, 0, '0, 0, '0, 0);
        step(0, 0, 1, 1, 0, '0, 0, '0, 0);
        step(0, 0, 1, 1, 0, '0, 1, 32'h1c000100, 0);
        step(0, 0, 1, 1, 0, '0, 0, '0, 0);
        run(10, 1, 1);
        #6;
        check("branch_stale_fires", n_stale - s0, 1);
        check("branch_drops", n_drop - d0, 1);

        // Saturate outstanding, then release one response.
        run(6, 1, 0);
        #6;
        check("full_outstanding", inflight_q.size(), MAXO);
        step(0, 1, 1, 1, 0, '0, 0, '0, 0);
        run(6, 1, 1);

        // Flush and branch in the same cycle.
        step(0, 1, 1, 1, 1, 32'h1c008000, 1, 32'h1c000200, 0);
        run(10, 1, 1);

        // Misaligned branch target stalls fetch until a flush.
        p0 = n_pseudo;
        step(0, 1, 1, 1, 0, '0, 1, 32'h1c000102, 0);
        run(5, 1, 1);
        #6;
        check("adef_pseudo", n_pseudo - p0, 1);
        step(0, 1, 1, 1, 1, 32'h1c008000, 0, '0, 0);
        run(10, 1, 1);

        // Reset with two requests outstanding; a stray response follows release.
        run(6, 1, 0);
        step(1, 0, 0, 0, 0, '0, 0, '0, 0);
        step(0, 1, 0, 1, 0, '0, 0, '0, 1);
        run(10, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            aok = $urandom_range(0, 3) != 0;
            dok = $urandom_range(0, 2) != 0;
            alw = $urandom_range(0, 4) != 0;
            fl  = stall_m ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
            br  = !stall_m && !unconsumed && ($urandom_range(0, 7) == 0);
            fpc = rand_target(0);
            bt  = rand_target($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 499) == 0) step(1, 0, 0, 0, 0, '0, 0, '0, 0);
            else step(0, aok, dok, alw, fl, fpc, br, bt, 0);
        end

        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0, '0, 0, '0, 0);
        #6;
        check("drained", inflight_q.size(), 0);
        check("progress", n_fire >= 300, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pre_if_stage.md
Name: pre_if_stage

Overview:
- Pre-IF stage of the LA32R 5-stage pipeline. Sits directly upstream of IF.
- Generates the next fetch PC (sequential, branch, or ertn/exception flush target) and drives the SRAM-like instruction bus request channel (req/addr_ok).
- Hands {pc, adef} to IF on a valid/allowin handshake.
- Tracks outstanding requests and marks stale responses that follow a redirect so IF drops them.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests (2..3).
- CNT_W, 2, width of the outstanding and cancel counters; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- br_bus  in  33  {br_taken, br_target[31:0]} from ID
- ws_flush  in  1  ertn/exception flush from WB
- flush_pc  in  32  flush target (era or eentry)
- fs_allowin  in  1  IF can accept a new PC
- ps_to_fs_valid  out  1  PC issued this cycle is handed to IF
- ps_to_fs_bus  out  33  {adef, pc[31:0]}
- inst_req  out  1  request valid
- inst_wr  out  1  constant 0
- inst_size  out  2  constant 2'b10
- inst_wstrb  out  4  constant 0
- inst_addr  out  32  request address
- inst_wdata  out  32  constant 0
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  a response returns this cycle
- resp_drop  out  1  the data_ok in this cycle is stale; IF must discard it

Behaviour:
- Reset values: inst_req=0, ps_to_fs_valid=0, resp_drop=0, outstanding=0, cancel_cnt=0, redirect latch empty. The next-PC register resets to RESET_PC.
- Accept (fire) = inst_req & inst_addr_ok. On fire: ps_to_fs_valid=1 the same cycle, ps_to_fs_bus={adef, inst_addr}, and the PC register advances to inst_addr+4.
- Request condition: inst_req=1 when all of the following hold: not in reset, fs_allowin=1, outstanding<MAX_OUTSTANDING, no flush this cycle.
- Address stability: once inst_req=1 and addr_ok=0, inst_addr and inst_req stay stable until fire. fs_allowin dropping does not retract a pending request.
- inst_addr priority, from highest:
  1. Latched redirect, when the latch is valid and no request is pending.
  2. Current-cycle flush_pc or br_target, when no request is pending.
  3. Sequential PC register.
- Redirect with no request pending: the new address is issued directly and the latch is not written.
- Redirect while a request is pending without addr_ok: the redirect is latched and the pending request completes unchanged. After it fires, that PC is stale: ps_to_fs_valid is forced to 0 for it and it is counted into cancel_cnt. The next request uses the latched address.
- Flush beats branch in the same cycle. A later flush overwrites a latched branch. A branch never overwrites a latched flush.
- On flush, inst_req is deasserted for that one cycle unless a request is already pending. Requests resume the next cycle at flush_pc.
- adef = (addr[1:0]!=0). An adef PC is not sent on the bus: inst_req=0 for it and it is passed to IF as a pseudo-fire (ps_to_fs_valid=1, no outstanding increment). Fetch then stalls until a flush.
- outstanding: +1 on fire, -1 on data_ok, net 0 when both happen in the same cycle. It never wraps; saturation at MAX_OUTSTANDING blocks inst_req.
- cancel_cnt:
  - On redirect, cancel_cnt <= outstanding (after this cycle's data_ok adjustment), plus 1 if a pending request fires later under the latch.
  - data_ok while cancel_cnt>0 gives resp_drop=1 and cancel_cnt-1.
- Reset at any point clears all state. Responses arriving after reset are not tracked: they see cancel_cnt=0, so resp_drop=0.

Decomposition:
- Shared header (mycpu_head): BR_BUS_WD=33, PS_TO_FS_BUS_WD=33, RESET_PC, and the size encoding.
- One natural sub-module: fetch_track_cnt, holding the outstanding and cancel counters with the saturation and drop logic.

Test Plan:
- Reset, then addr_ok held high and data_ok one cycle later -> addrs 1c000000, 1c000004, 1c000008 on consecutive cycles, resp_drop=0 throughout.
- addr_ok low for 3 cycles at 1c000004 with br_taken to 1c000100 in cycle 1 -> inst_addr stays 1c000004 until fire, that PC has ps_to_fs_valid=0, next addr is 1c000100, and its data_ok gives resp_drop=1.
- Two outstanding requests (MAX=2), data_ok withheld -> inst_req=0; one data_ok -> inst_req=1 the next cycle.
- ws_flush=1 with flush_pc=1c008000 in the same cycle as br_taken to 1c000200 -> next addr is 1c008000, never 1c000200.
- br_target=1c000102 -> ps_to_fs_valid=1 with adef=1 and no bus request; a later flush to 1c008000 resumes fetch.
- Reset asserted while outstanding=2 -> counters 0 and inst_req=0 in the cycle after reset; the first request after release is to RESET_PC.
